mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single unified memory port between the scalar core's instruction-fetch interface (imem) and data interface (dmem). It sits between SOC_TOP's core ports and MEMORY_TOP. It serialises requests with a registered grant FSM, forwards the memory response to the granted requester, and keeps per-requester grant counters for performance reporting alongside mcycle/minstret.

---
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between the core's instruction-fetch side
// (imem) and data side (dmem). A registered grant FSM serialises requests: an
// IDLE cycle picks a winner and latches its address, write enable and write
// data. The FSM then holds mem_req_o high until memory answers with
// mem_ready_i. That response is steered combinationally back to the winner,
// and the winner's grant counter is bumped.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   - contention in IDLE goes to the requester not granted last
//               (1-bit pointer, starts out favouring imem).
//   undefined - fixed priority; dmem always wins contention.
//
// Parameters
//   DWidth    data / address width
//   CntWidth  width of each grant counter
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   imem_req_i/addr_i     fetch request, held until imem_ready_o
//   imem_ready_o/rdata_o  one-cycle fetch response; rdata is 0 when not ready
//   dmem_req_i/write_i/addr_i/wdata_i  data request, held until dmem_ready_o
//   dmem_ready_o/rdata_o  one-cycle data response; rdata is 0 when not ready
//   mem_req_o/write_o/addr_o/wdata_o   registered request to shared memory
//   mem_ready_i/rdata_i   memory response strobe and read data
//   imem_grant_cnt_o      completed fetch transactions (wraps)
//   dmem_grant_cnt_o      completed data transactions (wraps)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DWidth   = 32,
  parameter int CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // fetch side
  input  logic                imem_req_i,
  input  logic [DWidth-1:0]   imem_addr_i,
  output logic                imem_ready_o,
  output logic [DWidth-1:0]   imem_rdata_o,
  // data side
  input  logic                dmem_req_i,
  input  logic                dmem_write_i,
  input  logic [DWidth-1:0]   dmem_addr_i,
  input  logic [DWidth-1:0]   dmem_wdata_i,
  output logic                dmem_ready_o,
  output logic [DWidth-1:0]   dmem_rdata_o,
  // shared memory port
  output logic                mem_req_o,
  output logic                mem_write_o,
  output logic [DWidth-1:0]   mem_addr_o,
  output logic [DWidth-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DWidth-1:0]   mem_rdata_i,
  // performance counters
  output logic [CntWidth-1:0] imem_grant_cnt_o,
  output logic [CntWidth-1:0] dmem_grant_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_write_q, mem_write_d;
  logic [DWidth-1:0]   mem_addr_q, mem_addr_d;
  logic [DWidth-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CntWidth-1:0] imem_cnt_q, imem_cnt_d;
  logic [CntWidth-1:0] dmem_cnt_q, dmem_cnt_d;

  // Winner selection, only meaningful while in IDLE.
  logic win_imem, win_dmem;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = dmem has priority on the next contention, 0 = imem has it.
  logic rr_dmem_next_q, rr_dmem_next_d;

  always_comb begin
    win_imem = 1'b0;
    win_dmem = 1'b0;
    if (imem_req_i && dmem_req_i) begin
      win_dmem = rr_dmem_next_q;
      win_imem = ~rr_dmem_next_q;
    end else begin
      win_imem = imem_req_i;
      win_dmem = dmem_req_i;
    end
  end

  // The pointer moves on every grant, contended or not, so it always
  // favours whichever side was not served last.
  always_comb begin
    rr_dmem_next_d = rr_dmem_next_q;
    if (state_q == IDLE && (win_imem || win_dmem)) begin
      rr_dmem_next_d = win_imem;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_dmem_next_q <= 1'b0;
    end else begin
      rr_dmem_next_q <= rr_dmem_next_d;
    end
  end
`else
  // Fixed priority: dmem wins any contention.
  always_comb begin
    win_dmem = dmem_req_i;
    win_imem = imem_req_i & ~dmem_req_i;
  end
`endif

  // Next-state and response steering.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    imem_cnt_d   = imem_cnt_q;
    dmem_cnt_d   = dmem_cnt_q;
    imem_ready_o = 1'b0;
    imem_rdata_o = '0;
    dmem_ready_o = 1'b0;
    dmem_rdata_o = '0;

    unique case (state_q)
      IDLE: begin
        // mem_ready_i is deliberately ignored here: nothing is outstanding.
        if (win_dmem) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_write_d = dmem_write_i;
          mem_addr_d  = dmem_addr_i;
          mem_wdata_d = dmem_wdata_i;
        end else if (win_imem) begin
          // Fetches never write; wdata keeps whatever it last held.
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = imem_addr_i;
        end
      end

      BUSY_I: begin
        if (mem_ready_i) begin
          imem_ready_o = 1'b1;
          imem_rdata_o = mem_rdata_i;
          imem_cnt_d   = imem_cnt_q + 1'b1;
          mem_req_d    = 1'b0;
          state_d      = IDLE;
        end
      end

      BUSY_D: begin
        if (mem_ready_i) begin
          dmem_ready_o = 1'b1;
          dmem_rdata_o = mem_rdata_i;
          dmem_cnt_d   = dmem_cnt_q + 1'b1;
          mem_req_d    = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered memory-side outputs. A reset mid-transaction
  // drops mem_req_o at once and returns to IDLE, so a late mem_ready_i
  // lands in IDLE and is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      imem_cnt_q  <= '0;
      dmem_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of its inputs regardless of statement order.
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      imem_cnt_q  <= imem_cnt_d;
      dmem_cnt_q  <= dmem_cnt_d;
    end
  end

  assign mem_req_o        = mem_req_q;
  assign mem_write_o      = mem_write_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign imem_grant_cnt_o = imem_cnt_q;
  assign dmem_grant_cnt_o = dmem_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs change on the falling edge and
// are followed by a #1 settle; outputs are sampled there, away from the
// rising (active) edge. Expected values are hand-computed constants. The
// contention order depends on ARB_ROUND_ROBIN_EN being defined for the
// bench as well as the design.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_i;
  logic [31:0] imem_addr_i;
  logic        imem_ready_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i;
  logic        dmem_write_i;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_wdata_i;
  logic        dmem_ready_o;
  logic [31:0] dmem_rdata_o;
  logic        mem_req_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] imem_grant_cnt_o;
  logic [31:0] dmem_grant_cnt_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DWidth(32), .CntWidth(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_req_i       (imem_req_i),
    .imem_addr_i      (imem_addr_i),
    .imem_ready_o     (imem_ready_o),
    .imem_rdata_o     (imem_rdata_o),
    .dmem_req_i       (dmem_req_i),
    .dmem_write_i     (dmem_write_i),
    .dmem_addr_i      (dmem_addr_i),
    .dmem_wdata_i     (dmem_wdata_i),
    .dmem_ready_o     (dmem_ready_o),
    .dmem_rdata_o     (dmem_rdata_o),
    .mem_req_o        (mem_req_o),
    .mem_write_o      (mem_write_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_ready_i      (mem_ready_i),
    .mem_rdata_i      (mem_rdata_i),
    .imem_grant_cnt_o (imem_grant_cnt_o),
    .dmem_grant_cnt_o (dmem_grant_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected contention winners: 1 = dmem, 0 = imem.
`ifdef ARB_ROUND_ROBIN_EN
  logic [3:0] exp_d_order = 4'b1010;  // bit k = transaction k: I,D,I,D
  logic [31:0] exp_i_cnt_after = 32'd3;
  logic [31:0] exp_d_cnt_after = 32'd3;
`else
  logic [3:0] exp_d_order = 4'b1111;  // D,D,D,D
  logic [31:0] exp_i_cnt_after = 32'd1;
  logic [31:0] exp_d_cnt_after = 32'd5;
`endif

  initial begin
    logic is_d;
    rst_i        = 1'b1;
    imem_req_i   = 1'b0;
    imem_addr_i  = '0;
    dmem_req_i   = 1'b0;
    dmem_write_i = 1'b0;
    dmem_addr_i  = '0;
    dmem_wdata_i = '0;
    mem_ready_i  = 1'b0;
    mem_rdata_i  = '0;

    // ---- reset state ----
    @(negedge clk_i); #1;
    check1("rst_mem_req", mem_req_o, 1'b0);
    check1("rst_mem_write", mem_write_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    check("rst_icnt", imem_grant_cnt_o, 32'h0);
    check("rst_dcnt", dmem_grant_cnt_o, 32'h0);
    check1("rst_iready", imem_ready_o, 1'b0);
    check1("rst_dready", dmem_ready_o, 1'b0);
    check("rst_irdata", imem_rdata_o, 32'h0);
    check("rst_drdata", dmem_rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // ---- lone imem fetch, memory answers on 3rd BUSY cycle ----
    @(negedge clk_i);
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h0000_0010;
    mem_rdata_i = 32'h0000_0013;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      if (c == 3) mem_ready_i = 1'b1;
      #1;
      check1("f_mem_req", mem_req_o, 1'b1);
      check("f_mem_addr", mem_addr_o, 32'h0000_0010);
      check1("f_mem_write", mem_write_o, 1'b0);
      check1("f_iready", imem_ready_o, (c == 3));
      check("f_irdata", imem_rdata_o, (c == 3) ? 32'h0000_0013 : 32'h0);
      check1("f_dready", dmem_ready_o, 1'b0);
    end
    imem_req_i = 1'b0;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1;
    check1("f_done_req", mem_req_o, 1'b0);
    check1("f_done_iready", imem_ready_o, 1'b0);
    check("f_icnt", imem_grant_cnt_o, 32'd1);
    check("f_dcnt", dmem_grant_cnt_o, 32'd0);

    // ---- dmem store, memory answers in first BUSY cycle ----
    dmem_req_i   = 1'b1;
    dmem_write_i = 1'b1;
    dmem_addr_i  = 32'h0000_4000;
    dmem_wdata_i = 32'hDEAD_BEEF;
    mem_rdata_i  = 32'h1234_5678;
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    #1;
    check1("s_mem_req", mem_req_o, 1'b1);
    check1("s_mem_write", mem_write_o, 1'b1);
    check("s_mem_addr", mem_addr_o, 32'h0000_4000);
    check("s_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check1("s_dready", dmem_ready_o, 1'b1);
    check("s_drdata", dmem_rdata_o, 32'h1234_5678);
    check1("s_iready", imem_ready_o, 1'b0);
    check("s_irdata", imem_rdata_o, 32'h0);
    dmem_req_i = 1'b0;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1;
    check("s_dcnt", dmem_grant_cnt_o, 32'd1);
    check("s_icnt", imem_grant_cnt_o, 32'd1);
    check1("s_done_req", mem_req_o, 1'b0);

    // ---- spurious mem_ready_i while IDLE ----
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    check1("sp_iready", imem_ready_o, 1'b0);
    check1("sp_dready", dmem_ready_o, 1'b0);
    check("sp_drdata", dmem_rdata_o, 32'h0);
    @(negedge clk_i);
    #1;
    check1("sp_iready2", imem_ready_o, 1'b0);
    check1("sp_mem_req", mem_req_o, 1'b0);
    check("sp_icnt", imem_grant_cnt_o, 32'd1);
    check("sp_dcnt", dmem_grant_cnt_o, 32'd1);
    mem_ready_i = 1'b0;

    // ---- continuous contention, 4 transactions ----
    imem_req_i   = 1'b1;
    imem_addr_i  = 32'h0000_0100;
    dmem_req_i   = 1'b1;
    dmem_write_i = 1'b0;
    dmem_addr_i  = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      is_d = exp_d_order[k];
      @(negedge clk_i);
      mem_rdata_i = 32'h0000_00A0 + k;
      mem_ready_i = 1'b1;
      #1;
      check1("c_mem_req", mem_req_o, 1'b1);
      check("c_mem_addr", mem_addr_o, is_d ? 32'h0000_0200 : 32'h0000_0100);
      check1("c_mem_write", mem_write_o, 1'b0);
      check1("c_dready", dmem_ready_o, is_d);
      check1("c_iready", imem_ready_o, ~is_d);
      check("c_rdata", is_d ? dmem_rdata_o : imem_rdata_o, 32'h0000_00A0 + k);
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      #1;
      check1("c_bubble_req", mem_req_o, 1'b0);
    end
    imem_req_i = 1'b0;
    dmem_req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check1("c_idle_req", mem_req_o, 1'b0);
    check("c_icnt", imem_grant_cnt_o, exp_i_cnt_after);
    check("c_dcnt", dmem_grant_cnt_o, exp_d_cnt_after);

    // ---- reset in BUSY_D, then a late mem_ready_i ----
    dmem_req_i   = 1'b1;
    dmem_write_i = 1'b1;
    dmem_addr_i  = 32'h0000_0300;
    @(negedge clk_i);
    #1;
    check1("r_busy_req", mem_req_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check1("r_req_async", mem_req_o, 1'b0);
    check("r_icnt", imem_grant_cnt_o, 32'd0);
    check("r_dcnt", dmem_grant_cnt_o, 32'd0);
    mem_ready_i = 1'b1;
    #1;
    check1("r_dready", dmem_ready_o, 1'b0);
    dmem_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    check1("r_dready2", dmem_ready_o, 1'b0);
    check1("r_req_after", mem_req_o, 1'b0);
    check("r_dcnt2", dmem_grant_cnt_o, 32'd0);
    mem_ready_i = 1'b0;

    // ---- counter wrap ----
    force dut.imem_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.imem_cnt_q;
    #1;
    check("w_preset", imem_grant_cnt_o, 32'hFFFF_FFFF);
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h0000_0040;
    mem_rdata_i = 32'h0000_0077;
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    #1;
    check1("w_iready", imem_ready_o, 1'b1);
    imem_req_i = 1'b0;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1;
    check("w_icnt_wrap", imem_grant_cnt_o, 32'h0);
    check("w_dcnt", dmem_grant_cnt_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
